aoc_result_formatter: RTL and testbench
=======================================

# aoc_result_formatter

Streaming reader for the coprocessor result port. Captures a `WIDTH_DOUT`-bit unsigned answer on a `dout_valid` pulse and converts it to decimal with an iterative double-dabble. It then emits the answer as ASCII digits, most significant first with leading zeros suppressed, followed by an optional line feed, over a valid/ready byte stream. It sits between `coprocessor` and the board UART transmitter, so puzzle answers reach the host as text.

## Interface
- `WIDTH_DOUT`, 128: width of the captured result.
- `DIGITS`, 39: BCD digit count; must satisfy 10^DIGITS > 2^WIDTH_DOUT.
- `NEWLINE`, 1: 1 = append 0x0A after the last digit; 0 = no terminator.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `dout` in WIDTH_DOUT: result from coprocessor, unsigned.
- `dout_valid` in 1: one-cycle strobe marking `dout` valid.
- `tx_data` out 8: ASCII byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte this cycle.
- `busy` out 1: high from capture until the final byte is accepted.
- `overrun` out 1: sticky; a `dout_valid` arrived while busy.

## Operation
- States:
  - IDLE: waits for `dout_valid`.
  - CONVERT: WIDTH_DOUT steps.
  - SKIP: leading-zero suppression.
  - EMIT: digits.
  - TERM: line feed.
- IDLE: on an edge with `dout_valid`=1, load the binary shift register with `dout`, clear the BCD register and step counter, and go to CONVERT.
- CONVERT, one step per edge:
  - add 3 to every BCD digit that is ≥5;
  - then shift {bcd, bin} left by one.
  - After WIDTH_DOUT steps, go to SKIP with digit pointer = DIGITS-1.
- SKIP, per edge:
  - if digit[ptr]==0 and ptr>0, decrement ptr;
  - otherwise go to EMIT.
  - A value of 0 therefore emits the single digit "0".
- EMIT:
  - `tx_data` = 0x30 + digit[ptr], `tx_valid`=1.
  - On a handshake edge (`tx_valid` and `tx_ready`), if ptr>0, decrement ptr.
  - Else go to TERM if NEWLINE=1, or to IDLE if NEWLINE=0.
- TERM: `tx_data`=0x0A, `tx_valid`=1. The handshake edge returns to IDLE.
- Arithmetic is unsigned throughout; `dout` bits above WIDTH_DOUT do not exist. No sign handling.
- Overrun: `dout_valid`=1 in any state other than IDLE sets `overrun`. The new value is discarded and the conversion in progress is unaffected. `overrun` clears only on reset.
- Reset (`rst`=0), at any time including mid-conversion or mid-emission:
  - state→IDLE immediately (asynchronous);
  - `tx_valid`=0, `tx_data`=0x00, `busy`=0, `overrun`=0;
  - all registers cleared.
  - A partially emitted number is abandoned and not resumed.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `busy`=0, `overrun`=0.
- Capture edge E0: `busy` goes high after E0.
- CONVERT occupies edges E1..E_WIDTH_DOUT.
- For an n-digit result, SKIP uses DIGITS-n+1 edges. `tx_valid` first goes high after edge E(WIDTH_DOUT+DIGITS-n+1). For the defaults and n=1, that is after E167.
- Backpressure:
  - while `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold stable;
  - `tx_valid` never drops without a handshake, except on reset.
- With `tx_ready` held high, consecutive bytes go out on consecutive cycles.
- `busy` falls after the final handshake edge; `busy` is registered and equals (state != IDLE).
- A `dout_valid` in the first cycle after `busy` falls is captured normally.
- A `dout_valid` on the same edge as the final handshake counts as overrun.
- `tx_valid` is a registered output and does not depend combinationally on `tx_ready`.

## Test plan
- `dout`=3, `tx_ready`=1 → bytes 0x33, 0x0A. `tx_valid` first high after E167. `busy` low after the 0x0A handshake.
- `dout`=0 → bytes 0x30, 0x0A (single zero, no suppression of the last digit).
- `dout`=2^128-1 → 39 bytes "340282366920938463463374607431768211455" then 0x0A. First `tx_valid` after E129.
- `dout`=1050 with `tx_ready` toggled 1,0,0,1,0,1 repeatedly → stream "1050\n" exact. `tx_data` stable during every stall.
- Second `dout_valid` (value 7) 10 cycles after capturing 6 → `overrun`=1. Output is "6\n" only. A later clean `dout_valid` of 7 → "7\n" with `overrun` still 1.
- `rst` pulled low while the third digit of 12345 is pending → `tx_valid`, `busy` and `overrun` are 0 in the same cycle. After release, `dout`=6 → "6\n".

Source files
------------

// File: rtl/aoc_result_formatter.sv
// Captures a coprocessor result, converts it to BCD with an iterative double-dabble,
// and streams it as ASCII decimal (leading zeros suppressed, optional line feed).
module aoc_result_formatter #(
    parameter int WIDTH_DOUT = 128,
    parameter int DIGITS     = 39,
    parameter int NEWLINE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DOUT-1:0] dout,
    input  logic                  dout_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH_DOUT + 1);
    localparam int PTR_W = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SKIP    = 3'd2,
        EMIT    = 3'd3,
        TERM    = 3'd4
    } state_t;

    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic [PTR_W-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = (idx == PTR_W'(i)) ? b[4*i +: 4] : d;
        end
        return d;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    state_t                state_r, state_s;
    logic [WIDTH_DOUT-1:0] bin_r, bin_s;
    logic [BCD_W-1:0]      bcd_r, bcd_s, adj_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [PTR_W-1:0]      ptr_r, ptr_s;
    logic [7:0]            tx_data_r, tx_data_s;
    logic                  tx_valid_r, tx_valid_s;
    logic                  busy_r, busy_s;
    logic                  overrun_r, overrun_s;
    logic                  hs_s;
    logic [3:0]            cur_digit_s, next_digit_s;

    assign adj_s        = add3_all(bcd_r);
    assign hs_s         = tx_valid_r & tx_ready;
    assign cur_digit_s  = digit_at(bcd_r, ptr_r);
    assign next_digit_s = digit_at(bcd_r, ptr_r - PTR_W'(1));

    // Next-state and next-output logic for the capture/convert/emit sequence
    always_comb begin
        state_s    = state_r;
        bin_s      = bin_r;
        bcd_s      = bcd_r;
        cnt_s      = cnt_r;
        ptr_s      = ptr_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        case (state_r)
            IDLE: begin
                if (dout_valid) begin
                    bin_s   = dout;
                    bcd_s   = '0;
                    cnt_s   = '0;
                    state_s = CONVERT;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVERT: begin
                bcd_s = {adj_s[BCD_W-2:0], bin_r[WIDTH_DOUT-1]};
                bin_s = {bin_r[WIDTH_DOUT-2:0], 1'b0};
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH_DOUT - 1)) begin
                    state_s = SKIP;
                    ptr_s   = PTR_W'(DIGITS - 1);
                end else begin
                    state_s = CONVERT;
                end
            end
            SKIP: begin
                if ((cur_digit_s == 4'd0) && (ptr_r != PTR_W'(0))) begin
                    ptr_s = ptr_r - PTR_W'(1);
                end else begin
                    state_s    = EMIT;
                    tx_valid_s = 1'b1;
                    tx_data_s  = to_ascii(cur_digit_s);
                end
            end
            EMIT: begin
                if (!hs_s) begin
                    state_s = EMIT;
                end else if (ptr_r != PTR_W'(0)) begin
                    ptr_s     = ptr_r - PTR_W'(1);
                    tx_data_s = to_ascii(next_digit_s);
                end else if (NEWLINE == 1) begin
                    state_s   = TERM;
                    tx_data_s = 8'h0A;
                end else begin
                    state_s    = IDLE;
                    tx_valid_s = 1'b0;
                    tx_data_s  = 8'h00;
                end
            end
            TERM: begin
                if (hs_s) begin
                    state_s    = IDLE;
                    tx_valid_s = 1'b0;
                    tx_data_s  = 8'h00;
                end else begin
                    state_s = TERM;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
                tx_data_s  = 8'h00;
            end
        endcase
        // A capture request outside IDLE is dropped but remembered until reset
        if (dout_valid && (state_r != IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
        busy_s = (state_s != IDLE);
    end

    // State and registered-output update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            bin_r      <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ptr_r      <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            bin_r      <= bin_s;
            bcd_r      <= bcd_s;
            cnt_r      <= cnt_s;
            ptr_r      <= ptr_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            overrun_r  <= overrun_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_aoc_result_formatter.sv
// Table-driven bench for aoc_result_formatter: latency, byte stream, backpressure,
// overrun and asynchronous reset behaviour with hand-computed expectations.
module tb_aoc_result_formatter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] dout;
    logic         dout_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [127:0] value;
        logic [319:0] text;
        logic [7:0]   len;
        logic [15:0]  first_valid;
        logic         rmode;
        logic         inj;
        logic         ovr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    aoc_result_formatter #(
        .WIDTH_DOUT(128),
        .DIGITS    (39),
        .NEWLINE   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dout      (dout),
        .dout_valid(dout_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    function automatic logic [319:0] s2v(input string s);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            v = {v[311:0], s[i]};
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         k;
        int         idx;
        int         cyc;
        int         n;
        logic       stall;
        logic [7:0] held;
        logic [5:0] pat;
        pat   = 6'b101001;
        n     = int'(v.len);
        stall = 1'b0;
        held  = 8'h00;
        @(negedge clk);
        dout       = v.value;
        dout_valid = 1'b1;
        @(posedge clk);
        #1;
        dout_valid = 1'b0;
        chk("busy_after_capture", 128'(busy), 128'd1);
        k = 0;
        while (!tx_valid && k < 400) begin
            if (v.inj && k == 9) begin
                dout       = 128'd7;
                dout_valid = 1'b1;
            end else begin
                dout_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        dout_valid = 1'b0;
        chk("first_valid_edge", 128'(k), 128'(v.first_valid));
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            tx_ready = v.rmode ? pat[cyc % 6] : 1'b1;
            chk("tx_valid_held", 128'(tx_valid), 128'd1);
            if (stall) begin
                chk("stall_data_stable", 128'(tx_data), 128'(held));
            end
            if (tx_valid && tx_ready) begin
                chk("byte", 128'(tx_data), 128'(v.text[8*(n-1-idx) +: 8]));
                idx++;
                stall = 1'b0;
            end else begin
                stall = tx_valid;
                held  = tx_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        tx_ready = 1'b0;
        chk("bytes_done", 128'(idx), 128'(n));
        chk("busy_end", 128'(busy), 128'd0);
        chk("tx_valid_end", 128'(tx_valid), 128'd0);
        chk("overrun_end", 128'(overrun), 128'(v.ovr));
    endtask

    initial begin
        int k;
        rst        = 1'b0;
        dout       = 128'd0;
        dout_valid = 1'b0;
        tx_ready   = 1'b0;

        vecs[0] = '{value: 128'd3, text: s2v("3\n"), len: 8'd2, first_valid: 16'd167,
                    rmode: 1'b0, inj: 1'b0, ovr: 1'b0};
        vecs[1] = '{value: 128'd0, text: s2v("0\n"), len: 8'd2, first_valid: 16'd167,
                    rmode: 1'b0, inj: 1'b0, ovr: 1'b0};
        vecs[2] = '{value: {128{1'b1}}, text: s2v("340282366920938463463374607431768211455\n"),
                    len: 8'd40, first_valid: 16'd129, rmode: 1'b0, inj: 1'b0, ovr: 1'b0};
        vecs[3] = '{value: 128'd1050, text: s2v("1050\n"), len: 8'd5, first_valid: 16'd164,
                    rmode: 1'b1, inj: 1'b0, ovr: 1'b0};
        vecs[4] = '{value: 128'd6, text: s2v("6\n"), len: 8'd2, first_valid: 16'd167,
                    rmode: 1'b0, inj: 1'b1, ovr: 1'b1};
        vecs[5] = '{value: 128'd7, text: s2v("7\n"), len: 8'd2, first_valid: 16'd167,
                    rmode: 1'b0, inj: 1'b0, ovr: 1'b1};
        vecs[6] = '{value: 128'd6, text: s2v("6\n"), len: 8'd2, first_valid: 16'd167,
                    rmode: 1'b1, inj: 1'b0, ovr: 1'b0};

        #1;
        chk("reset_tx_data", 128'(tx_data), 128'h00);
        chk("reset_tx_valid", 128'(tx_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_overrun", 128'(overrun), 128'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abandon 12345 while its third digit is waiting, with overrun still set
        @(negedge clk);
        dout       = 128'd12345;
        dout_valid = 1'b1;
        @(posedge clk);
        #1;
        dout_valid = 1'b0;
        k = 0;
        while (!tx_valid && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rst_seq_first_valid", 128'(k), 128'd163);
        chk("rst_seq_digit1", 128'(tx_data), 128'h31);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_seq_digit2", 128'(tx_data), 128'h32);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("rst_seq_digit3", 128'(tx_data), 128'h33);
        chk("rst_seq_overrun_before", 128'(overrun), 128'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_async_busy", 128'(busy), 128'd0);
        chk("rst_async_overrun", 128'(overrun), 128'd0);
        chk("rst_async_tx_data", 128'(tx_data), 128'h00);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
